// File: rtl/me_best_mv_search_if.sv
// Handshake bundle for the best motion-vector search stage.
// master drives SAD beats and consumes results; slave is the search block.
interface me_best_mv_search_if #(
    parameter int BATCH = 16,
    parameter int SAD_W = 14,
    parameter int MVX_W = 6,
    parameter int MVY_W = 5
);
    logic                     sad_valid;
    logic                     sad_ready;
    logic                     sad_first;
    logic [BATCH*SAD_W-1:0]   sad_batch;
    logic                     early_en;
    logic [SAD_W-1:0]         thresh;
    logic                     best_valid;
    logic                     best_ready;
    logic [SAD_W-1:0]         best_sad;
    logic [MVX_W-1:0]         best_mvx;
    logic [MVY_W-1:0]         best_mvy;
    logic                     best_early;
    logic                     err_seq;

    modport master (
        output sad_valid,
        output sad_first,
        output sad_batch,
        output early_en,
        output thresh,
        output best_ready,
        input  sad_ready,
        input  best_valid,
        input  best_sad,
        input  best_mvx,
        input  best_mvy,
        input  best_early,
        input  err_seq
    );

    modport slave (
        input  sad_valid,
        input  sad_first,
        input  sad_batch,
        input  early_en,
        input  thresh,
        input  best_ready,
        output sad_ready,
        output best_valid,
        output best_sad,
        output best_mvx,
        output best_mvy,
        output best_early,
        output err_seq
    );
endinterface

// File: rtl/me_best_mv_search.sv
// Running-minimum SAD search over a full window, emitting best SAD + MV.
// Two register stages: lane-min tree (S1), running compare + output (S2).
module me_best_mv_search #(
    parameter int BATCH    = 16,
    parameter int SAD_W    = 14,
    parameter int SEARCH_W = 64,
    parameter int SEARCH_H = 32
) (
    input  logic clk,
    input  logic rst,
    me_best_mv_search_if.slave io_if
);
    localparam int MVX_W = $clog2(SEARCH_W);
    localparam int MVY_W = $clog2(SEARCH_H);
    localparam int NBEAT = SEARCH_W * SEARCH_H / BATCH;
    localparam int LW    = $clog2(BATCH);
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int IDXW  = $clog2(SEARCH_W * SEARCH_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    logic [BW-1:0]      r_beat_cnt;
    logic               r_err;

    logic               r_s1_vld;
    logic               r_s1_start;
    logic               r_s1_last;
    logic [BW-1:0]      r_s1_beat;
    logic [LW-1:0]      r_s1_lane;
    logic [SAD_W-1:0]   r_s1_sad;
    logic               r_s1_early_en;
    logic [SAD_W-1:0]   r_s1_thresh;

    logic [SAD_W-1:0]   r_run_sad;
    logic [IDXW-1:0]    r_run_idx;
    logic               r_dead;

    logic               r_best_valid;
    logic [SAD_W-1:0]   r_best_sad;
    logic [MVX_W-1:0]   r_best_mvx;
    logic [MVY_W-1:0]   r_best_mvy;
    logic               r_best_early;

    logic               w_stall;
    logic               w_acc;
    logic               w_push;
    logic               w_start;
    logic               w_err;
    logic [BW-1:0]      w_beat;
    logic               w_last;

    logic [SAD_W-1:0]   w_tsad  [1:2*BATCH-1];
    logic [LW-1:0]      w_tlane [1:2*BATCH-1];

    logic               w_s2_go;
    logic [SAD_W-1:0]   w_base_sad;
    logic [IDXW-1:0]    w_base_idx;
    logic               w_base_dead;
    logic [IDXW-1:0]    w_s1_idx;
    logic               w_upd;
    logic [SAD_W-1:0]   w_new_sad;
    logic [IDXW-1:0]    w_new_idx;
    logic               w_fire_early;
    logic               w_fire_end;
    logic               w_emit;

    // A held result freezes the whole pipe, including input acceptance.
    assign w_stall = r_best_valid & ~io_if.best_ready;
    assign w_acc   = io_if.sad_valid & ~w_stall;

    assign io_if.sad_ready  = ~w_stall;
    assign io_if.best_valid = r_best_valid;
    assign io_if.best_sad   = r_best_sad;
    assign io_if.best_mvx   = r_best_mvx;
    assign io_if.best_mvy   = r_best_mvy;
    assign io_if.best_early = r_best_early;
    assign io_if.err_seq    = r_err;

    // Classify the accepted beat: forward to S1, start a block, or flag error.
    always_comb begin
        w_push  = 1'b0;
        w_start = 1'b0;
        w_err   = 1'b0;
        w_beat  = r_beat_cnt;
        if (w_acc) begin
            case (r_state)
                ST_IDLE: begin
                    if (io_if.sad_first) begin
                        w_push  = 1'b1;
                        w_start = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_ACC: begin
                    w_push = 1'b1;
                    if (io_if.sad_first) begin
                        w_start = 1'b1;
                        w_err   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (io_if.sad_first) begin
                        w_push  = 1'b1;
                        w_start = 1'b1;
                        w_err   = 1'b1;
                    end
                end
                default: begin
                    w_push = 1'b0;
                end
            endcase
            if (w_start) begin
                w_beat = '0;
            end
        end
    end

    assign w_last = (w_beat == BW'(NBEAT - 1));

    // Block sequencing FSM with registered protocol-error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_acc && io_if.sad_first) begin
                r_beat_cnt <= BW'(1);
                r_state    <= w_last ? ST_IDLE : ST_ACC;
            end else if (w_acc && r_state != ST_IDLE) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (w_last) begin
                    r_state <= ST_IDLE;
                end else if (r_state == ST_ACC && w_fire_early) begin
                    r_state <= ST_DRAIN;
                end
            end else if (r_state == ST_ACC && w_fire_early) begin
                r_state <= ST_DRAIN;
            end
        end
    end

    // Binary min tree over the lanes; left child (lower lane) wins ties.
    always_comb begin
        for (int k = 0; k < BATCH; k++) begin
            w_tsad[BATCH+k]  = io_if.sad_batch[k*SAD_W +: SAD_W];
            w_tlane[BATCH+k] = LW'(k);
        end
        for (int n = BATCH - 1; n >= 1; n--) begin
            if (w_tsad[2*n+1] < w_tsad[2*n]) begin
                w_tsad[n]  = w_tsad[2*n+1];
                w_tlane[n] = w_tlane[2*n+1];
            end else begin
                w_tsad[n]  = w_tsad[2*n];
                w_tlane[n] = w_tlane[2*n];
            end
        end
    end

    // S1: capture the batch minimum with its position and beat controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld      <= 1'b0;
            r_s1_start    <= 1'b0;
            r_s1_last     <= 1'b0;
            r_s1_beat     <= '0;
            r_s1_lane     <= '0;
            r_s1_sad      <= '0;
            r_s1_early_en <= 1'b0;
            r_s1_thresh   <= '0;
        end else if (!w_stall) begin
            r_s1_vld      <= w_push;
            r_s1_start    <= w_start;
            r_s1_last     <= w_last;
            r_s1_beat     <= w_beat;
            r_s1_lane     <= w_tlane[1];
            r_s1_sad      <= w_tsad[1];
            r_s1_early_en <= io_if.early_en;
            r_s1_thresh   <= io_if.thresh;
        end
    end

    // A start beat restarts the running min from all-ones.
    assign w_s2_go     = r_s1_vld & ~w_stall;
    assign w_base_sad  = r_s1_start ? {SAD_W{1'b1}} : r_run_sad;
    assign w_base_idx  = r_s1_start ? '0 : r_run_idx;
    assign w_base_dead = r_s1_start ? 1'b0 : r_dead;
    assign w_s1_idx    = IDXW'(r_s1_beat) * IDXW'(BATCH) + IDXW'(r_s1_lane);
    assign w_upd       = r_s1_sad < w_base_sad;
    assign w_new_sad   = w_upd ? r_s1_sad : w_base_sad;
    assign w_new_idx   = w_upd ? w_s1_idx : w_base_idx;

    assign w_fire_early = w_s2_go & ~w_base_dead & r_s1_early_en &
                          ~r_s1_last & (w_new_sad <= r_s1_thresh);
    assign w_fire_end   = w_s2_go & ~w_base_dead & r_s1_last;
    assign w_emit       = w_fire_early | w_fire_end;

    // S2: running minimum; a block that already reported is marked dead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_sad <= '1;
            r_run_idx <= '0;
            r_dead    <= 1'b0;
        end else if (w_s2_go) begin
            r_run_sad <= w_new_sad;
            r_run_idx <= w_new_idx;
            r_dead    <= w_base_dead | w_fire_early;
        end
    end

    // Output register: loads on emit, holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_valid <= 1'b0;
            r_best_sad   <= '0;
            r_best_mvx   <= '0;
            r_best_mvy   <= '0;
            r_best_early <= 1'b0;
        end else if (!w_stall) begin
            r_best_valid <= w_emit;
            if (w_emit) begin
                r_best_sad   <= w_new_sad;
                r_best_mvx   <= MVX_W'(w_new_idx % IDXW'(SEARCH_W));
                r_best_mvy   <= MVY_W'(w_new_idx / IDXW'(SEARCH_W));
                r_best_early <= w_fire_early;
            end
        end
    end
endmodule

// File: tb/tb_me_best_mv_search.sv
// Scoreboard bench for me_best_mv_search: directed blocks,
// expected results queued at issue, checked by a monitor on handshake.
module tb_me_best_mv_search;
    localparam int BATCH = 16;
    localparam int SAD_W = 14;
    localparam int SW    = 64;
    localparam int SH    = 32;
    localparam int NBEAT = SW * SH / BATCH;
    localparam int MVX_W = 6;
    localparam int MVY_W = 5;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MVX_W-1:0] x;
        logic [MVY_W-1:0] y;
        logic             early;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    me_best_mv_search_if #(
        .BATCH(BATCH), .SAD_W(SAD_W), .MVX_W(MVX_W), .MVY_W(MVY_W)
    ) bus ();

    me_best_mv_search #(
        .BATCH(BATCH), .SAD_W(SAD_W), .SEARCH_W(SW), .SEARCH_H(SH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .io_if(bus.slave)
    );

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   err_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t cur_res();
        res_t r;
        r.sad   = bus.best_sad;
        r.x     = bus.best_mvx;
        r.y     = bus.best_mvy;
        r.early = bus.best_early;
        return r;
    endfunction

    function automatic res_t mk(input int s, input int x, input int y, input bit e);
        res_t r;
        r.sad   = SAD_W'(s);
        r.x     = MVX_W'(x);
        r.y     = MVY_W'(y);
        r.early = e;
        return r;
    endfunction

    task automatic monitor();
        res_t act;
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.err_seq) err_cnt++;
                if (bus.best_valid && bus.best_ready) begin
                    act = cur_res();
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL result: unexpected sad=%0d x=%0d y=%0d e=%0d",
                                 act.sad, act.x, act.y, act.early);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            n_fail++;
                            $display("FAIL result: got sad=%0d x=%0d y=%0d e=%0d expected sad=%0d x=%0d y=%0d e=%0d",
                                     act.sad, act.x, act.y, act.early,
                                     e.sad, e.x, e.y, e.early);
                        end
                    end
                end
            end
        end
    endtask

    // Send nb beats; special values v1/v2 at candidate indices i1/i2.
    task automatic send_block(input int nb, input bit first0,
                              input int i1, input int v1,
                              input int i2, input int v2,
                              input bit een, input int th);
        int t;
        int idx;
        logic [SAD_W-1:0] v;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            bus.sad_valid = 1'b1;
            bus.sad_first = (b == 0) && first0;
            bus.early_en  = een;
            bus.thresh    = SAD_W'(th);
            for (int k = 0; k < BATCH; k++) begin
                idx = b * BATCH + k;
                v = SAD_W'(1000 + idx % 256);
                if (idx == i1) v = SAD_W'(v1);
                if (idx == i2) v = SAD_W'(v2);
                bus.sad_batch[k*SAD_W +: SAD_W] = v;
            end
            t = 0;
            while (!bus.sad_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                chk("accept_timeout", 1, 0);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.sad_valid = 1'b0;
        bus.sad_first = 1'b0;
        bus.early_en  = 1'b0;
    endtask

    initial begin
        int   e0;
        int   t;
        bit   stable;
        bit   rdy_low;
        res_t held;

        bus.sad_valid  = 1'b0;
        bus.sad_first  = 1'b0;
        bus.sad_batch  = '0;
        bus.early_en   = 1'b0;
        bus.thresh     = '0;
        bus.best_ready = 1'b1;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sad_ready", bus.sad_ready, 1);
        chk("rst_best_valid", bus.best_valid, 0);
        chk("rst_best_sad", bus.best_sad, 0);
        chk("rst_best_mvx", bus.best_mvx, 0);
        chk("rst_best_mvy", bus.best_mvy, 0);
        chk("rst_best_early", bus.best_early, 0);
        chk("rst_err_seq", bus.err_seq, 0);

        // Ramp: unique min at idx 1000, with latency check.
        exp_q.push_back(mk(5, 40, 15, 0));
        send_block(NBEAT, 1, 1000, 5, -1, 0, 0, 0);
        chk("ramp_lat_early", bus.best_valid, 0);
        @(posedge clk);
        #1;
        chk("ramp_lat", bus.best_valid, 1);
        repeat (3) @(negedge clk);

        // Tie across beats: earliest index wins.
        exp_q.push_back(mk(7, 3, 0, 0));
        send_block(NBEAT, 1, 3, 7, 700, 7, 0, 0);
        repeat (4) @(negedge clk);

        // Early stop on beat 4 lane 2; later smaller SAD must be ignored.
        exp_q.push_back(mk(9, 2, 1, 1));
        send_block(NBEAT, 1, 66, 9, 500, 3, 1, 10);
        repeat (6) @(negedge clk);
        chk("early_single", exp_q.size(), 0);

        // Backpressure: hold result for 20 cycles.
        bus.best_ready = 1'b0;
        exp_q.push_back(mk(20, 63, 31, 0));
        send_block(NBEAT, 1, 2047, 20, -1, 0, 0, 0);
        t = 0;
        while (!bus.best_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid", bus.best_valid, 1);
        held    = cur_res();
        stable  = 1'b1;
        rdy_low = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (cur_res() !== held || !bus.best_valid) stable = 1'b0;
            if (bus.sad_ready) rdy_low = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_sad_ready_low", rdy_low, 1);
        @(posedge clk);
        #1;
        bus.best_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Next block after release; lane tie inside a beat.
        exp_q.push_back(mk(11, 0, 0, 0));
        send_block(NBEAT, 1, 0, 11, 1, 11, 0, 0);
        repeat (4) @(negedge clk);

        // Abort at beat 50: error pulse, only the new block reports.
        e0 = err_cnt;
        send_block(50, 1, 10, 1, -1, 0, 0, 0);
        exp_q.push_back(mk(30, 0, 16, 0));
        send_block(NBEAT, 1, 1024, 30, -1, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("abort_err", err_cnt - e0, 1);

        // Stray beat in IDLE.
        e0 = err_cnt;
        send_block(1, 0, 0, 1, -1, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("idle_err", err_cnt - e0, 1);

        // Reset mid-block, then a fresh block.
        send_block(60, 1, 5, 1, -1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_sad_ready", bus.sad_ready, 1);
        chk("mid_rst_best_valid", bus.best_valid, 0);
        chk("mid_rst_best_sad", bus.best_sad, 0);
        chk("mid_rst_best_mvx", bus.best_mvx, 0);
        chk("mid_rst_best_mvy", bus.best_mvy, 0);
        chk("mid_rst_err_seq", bus.err_seq, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk(2, 28, 23, 0));
        send_block(NBEAT, 1, 1500, 2, -1, 0, 0, 0);
        repeat (6) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
